// File: rtl/rv32_pkg.sv
// rv32_pkg: shared types and constants for the instruction fetch slice.
//   fq_entry_t    - fetch-queue entry {instr, pc, err}
//   NOP           - canonical RV32 NOP encoding (addi x0, x0, 0)
//   fetch_state_e - fetch controller state (running / stalled on access fault)
package rv32_pkg;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        err;
  } fq_entry_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [0:0] {
    FS_RUN,
    FS_FAULT
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the redirect, I-cache request/response and decode
// handshake signals of fetch_unit.
//   master - fetch_unit side (drives ic_req_* and instr_* outputs)
//   slave  - environment side (redirect source, I-cache, decode stage)
interface fetch_unit_if;
  logic        redir_i;
  logic [31:0] redir_pc_i;
  logic        ic_req_valid_o;
  logic        ic_req_ready_i;
  logic [31:0] ic_req_addr_o;
  logic        ic_rsp_valid_i;
  logic [31:0] ic_rsp_data_i;
  logic        ic_rsp_err_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_err_o;

  modport master (
    input  redir_i, redir_pc_i, ic_req_ready_i,
    input  ic_rsp_valid_i, ic_rsp_data_i, ic_rsp_err_i, instr_ready_i,
    output ic_req_valid_o, ic_req_addr_o,
    output instr_valid_o, instr_o, instr_pc_o, instr_err_o
  );

  modport slave (
    output redir_i, redir_pc_i, ic_req_ready_i,
    output ic_rsp_valid_i, ic_rsp_data_i, ic_rsp_err_i, instr_ready_i,
    input  ic_req_valid_o, ic_req_addr_o,
    input  instr_valid_o, instr_o, instr_pc_o, instr_err_o
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO used for the fetch queue and the PC tag queue.
//   clk, rst       - clock, synchronous active-high reset
//   flush          - drop all entries (takes priority over push/pop)
//   push, wdata    - write port; a push while full is accepted only with a pop
//   pop, rdata     - read port; rdata is the registered head entry
//   full, empty    - status flags
//   count          - number of valid entries
// DEPTH must be a power of two (pointers wrap naturally).
module fetch_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push, do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch front end.
// Issues word-aligned I-cache requests from a registered PC, tags in-order
// responses with their PC, and buffers {instr, pc, err} in a fetch queue
// presented to decode. Requests are credit-limited so every response always
// has a queue slot. A redirect flushes the queue, reloads the PC and discards
// the responses still in flight. An access fault stalls fetch until redirect.
// Ports:
//   clk_i, rst_i - clock, synchronous active-high reset
//   bus          - fetch_unit_if.master (redirect, ic_req_*, ic_rsp_*, instr_*)
//   stat_fetched_o, stat_flush_o - decode-pop / redirect counters, present only
//                  when FETCH_STATS_EN is defined
// Parameters: RESET_PC, FQ_DEPTH (power of two, >= 2), MAX_OUTST (1..FQ_DEPTH).
module fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH  = 4,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  fetch_unit_if.master bus
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]  stat_fetched_o,
  output logic [31:0]  stat_flush_o
`endif
);
  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
  typedef logic [CW-1:0] cnt_t;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  cnt_t         outst_q, outst_d;
  cnt_t         drop_q, drop_d;

  fq_entry_t    fq_wdata, fq_head;
  logic         fq_push, fq_pop, fq_full, fq_empty;
  cnt_t         fq_count;
  logic [31:0]  tag_head;
  logic         tag_full, tag_empty;
  cnt_t         tag_count;

  logic         req_fire, rsp_seen, rsp_drop, rsp_accept;
  logic         unused_sink;

  assign unused_sink = ^{tag_count, fq_full};

  // Credit check counts both in-flight requests and queued entries so that a
  // response can always be pushed without back-pressure.
  assign bus.ic_req_valid_o = !rst_i && !bus.redir_i && (state_q == FS_RUN) &&
                              !tag_full && (outst_q < cnt_t'(MAX_OUTST)) &&
                              ((outst_q + fq_count) < cnt_t'(FQ_DEPTH));
  assign bus.ic_req_addr_o  = pc_q;
  assign req_fire           = bus.ic_req_valid_o && bus.ic_req_ready_i;

  // Responses with nothing in flight (e.g. stale ones after reset) are ignored.
  assign rsp_seen   = bus.ic_rsp_valid_i && (outst_q != '0);
  assign rsp_drop   = rsp_seen && (drop_q != '0);
  assign rsp_accept = rsp_seen && (drop_q == '0) && !bus.redir_i && !tag_empty;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    outst_d = outst_q + cnt_t'(req_fire) - cnt_t'(rsp_seen);
    if (bus.redir_i) begin
      // Everything still in flight after this cycle belongs to the old path.
      state_d = FS_RUN;
      pc_d    = {bus.redir_pc_i[31:2], 2'b00};
      drop_d  = outst_q - cnt_t'(rsp_seen);
    end else begin
      if (req_fire)   pc_d   = pc_q + 32'd4;
      if (rsp_drop)   drop_d = drop_q - cnt_t'(1);
      if (rsp_accept && bus.ic_rsp_err_i) state_d = FS_FAULT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FS_RUN;
      pc_q    <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end

  // PC tags of issued requests; flushed on redirect because discarded
  // responses never consult a tag.
  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (FQ_DEPTH)
  ) u_tag_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (bus.redir_i),
    .push  (req_fire),
    .wdata (pc_q),
    .pop   (rsp_accept),
    .rdata (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count)
  );

  assign fq_push  = rsp_accept;
  assign fq_wdata = '{instr: bus.ic_rsp_data_i, pc: tag_head, err: bus.ic_rsp_err_i};
  assign fq_pop   = bus.instr_valid_o && bus.instr_ready_i && !bus.redir_i;

  fetch_fifo #(
    .WIDTH ($bits(fq_entry_t)),
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk   (clk_i),
    .rst   (rst_i),
    .flush (bus.redir_i),
    .push  (fq_push),
    .wdata (fq_wdata),
    .pop   (fq_pop),
    .rdata (fq_head),
    .full  (fq_full),
    .empty (fq_empty),
    .count (fq_count)
  );

  // Queue storage is not reset, so outputs are zeroed while the queue is empty.
  assign bus.instr_valid_o = !fq_empty;
  assign bus.instr_o       = fq_empty ? '0 : fq_head.instr;
  assign bus.instr_pc_o    = fq_empty ? '0 : fq_head.pc;
  assign bus.instr_err_o   = !fq_empty && fq_head.err;

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_fetched_o <= '0;
      stat_flush_o   <= '0;
    end else begin
      if (fq_pop)      stat_fetched_o <= stat_fetched_o + 32'd1;
      if (bus.redir_i) stat_flush_o   <= stat_flush_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit
// (RESET_PC=0x100, FQ_DEPTH=4, MAX_OUTST=2). The bench plays the I-cache and
// decode stage by hand; expected values are hand-computed per step.
module tb_fetch_unit;
  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  fetch_unit_if bus ();

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_flush;
`endif

  fetch_unit #(
    .RESET_PC  (32'h0000_0100),
    .FQ_DEPTH  (4),
    .MAX_OUTST (2)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched_o (stat_fetched),
    .stat_flush_o   (stat_flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.redir_i        = 1'b0;
    bus.redir_pc_i     = '0;
    bus.ic_req_ready_i = 1'b0;
    bus.ic_rsp_valid_i = 1'b0;
    bus.ic_rsp_data_i  = '0;
    bus.ic_rsp_err_i   = 1'b0;
    bus.instr_ready_i  = 1'b0;

    // Reset state
    cyc(); cyc();
    chk1 ("rst_req_valid",   bus.ic_req_valid_o, 1'b0);
    chk1 ("rst_instr_valid", bus.instr_valid_o,  1'b0);
    chk32("rst_instr",       bus.instr_o,        32'h0);
    chk32("rst_instr_pc",    bus.instr_pc_o,     32'h0);
    chk1 ("rst_instr_err",   bus.instr_err_o,    1'b0);
    chk32("rst_addr",        bus.ic_req_addr_o,  32'h100);

    // Ready held low for three cycles: address and valid held
    rst = 1'b0;
    cyc();
    chk1 ("hold_valid0", bus.ic_req_valid_o, 1'b1);
    chk32("hold_addr0",  bus.ic_req_addr_o,  32'h100);
    cyc();
    chk32("hold_addr1",  bus.ic_req_addr_o,  32'h100);
    cyc();
    chk32("hold_addr2",  bus.ic_req_addr_o,  32'h100);
    chk1 ("hold_valid2", bus.ic_req_valid_o, 1'b1);

    // Sequential fetch 0x100, 0x104, 0x108, 0x10C with decode stalled
    bus.ic_req_ready_i = 1'b1;
    cyc();                                   // fire 0x100
    chk32("addr_104", bus.ic_req_addr_o, 32'h104);
    bus.ic_rsp_valid_i = 1'b1;
    bus.ic_rsp_data_i  = 32'h1111_0001;
    cyc();                                   // fire 0x104, rsp 0x100
    chk32("addr_108",     bus.ic_req_addr_o, 32'h108);
    chk1 ("first_ivalid", bus.instr_valid_o, 1'b1);
    chk32("first_instr",  bus.instr_o,       32'h1111_0001);
    chk32("first_ipc",    bus.instr_pc_o,    32'h100);
    chk1 ("first_ierr",   bus.instr_err_o,   1'b0);
    bus.ic_rsp_data_i = 32'h1111_0002;
    cyc();                                   // fire 0x108, rsp 0x104
    chk32("addr_10c",  bus.ic_req_addr_o,  32'h10C);
    chk1 ("valid_10c", bus.ic_req_valid_o, 1'b1);
    bus.ic_rsp_data_i = 32'h1111_0003;
    cyc();                                   // fire 0x10C, rsp 0x108
    chk1 ("credit_stall", bus.ic_req_valid_o, 1'b0);
    chk32("addr_110",     bus.ic_req_addr_o,  32'h110);
    chk32("head_held",    bus.instr_o,        32'h1111_0001);
    bus.ic_rsp_data_i = 32'h1111_0004;
    bus.ic_rsp_err_i  = 1'b1;
    cyc();                                   // faulting rsp 0x10C, queue full
    bus.ic_rsp_valid_i = 1'b0;
    bus.ic_rsp_err_i   = 1'b0;
    chk1 ("full_no_req", bus.ic_req_valid_o, 1'b0);
    cyc();
    chk1 ("full_no_req2", bus.ic_req_valid_o, 1'b0);
    chk32("head_pc_100",  bus.instr_pc_o,     32'h100);

    // Drain queue; fault keeps requests off
    bus.instr_ready_i = 1'b1;
    cyc();
    chk32("pop1_instr",  bus.instr_o,        32'h1111_0002);
    chk32("pop1_pc",     bus.instr_pc_o,     32'h104);
    chk1 ("fault_stall", bus.ic_req_valid_o, 1'b0);
    cyc();
    chk32("pop2_instr",  bus.instr_o,        32'h1111_0003);
    chk32("pop2_pc",     bus.instr_pc_o,     32'h108);
    cyc();
    chk32("err_instr",   bus.instr_o,        32'h1111_0004);
    chk32("err_pc",      bus.instr_pc_o,     32'h10C);
    chk1 ("err_flag",    bus.instr_err_o,    1'b1);
    cyc();
    chk1 ("drained",      bus.instr_valid_o,  1'b0);
    chk32("drained_instr", bus.instr_o,       32'h0);
    chk1 ("fault_stall2", bus.ic_req_valid_o, 1'b0);

    // Redirect clears fault
    bus.instr_ready_i = 1'b0;
    bus.redir_i       = 1'b1;
    bus.redir_pc_i    = 32'h200;
    cyc();
    bus.redir_i = 1'b0;
    #1;
    chk1 ("redir_resume", bus.ic_req_valid_o, 1'b1);
    chk32("redir_addr",   bus.ic_req_addr_o,  32'h200);
    cyc();                                   // fire 0x200
    cyc();                                   // fire 0x204
    chk1 ("max_outst", bus.ic_req_valid_o, 1'b0);
    chk32("addr_208",  bus.ic_req_addr_o,  32'h208);

    // Redirect with two outstanding: both old responses dropped
    bus.redir_i    = 1'b1;
    bus.redir_pc_i = 32'h2002;
    #1;
    chk1("redir_suppress", bus.ic_req_valid_o, 1'b0);
    cyc();
    bus.redir_i = 1'b0;
    #1;
    chk32("redir_aligned", bus.ic_req_addr_o, 32'h2000);
    bus.ic_rsp_valid_i = 1'b1;
    bus.ic_rsp_data_i  = 32'hDEAD_0001;
    cyc();                                   // old rsp 0x200 dropped
    chk1("drop1",         bus.instr_valid_o,  1'b0);
    chk1("req_after_drop", bus.ic_req_valid_o, 1'b1);
    bus.ic_rsp_data_i = 32'hDEAD_0002;
    cyc();                                   // fire 0x2000, old rsp 0x204 dropped
    chk1 ("drop2",     bus.instr_valid_o, 1'b0);
    chk32("addr_2004", bus.ic_req_addr_o, 32'h2004);
    bus.ic_req_ready_i = 1'b0;
    bus.ic_rsp_data_i  = 32'h2000_AAAA;
    cyc();                                   // rsp 0x2000 kept
    bus.ic_rsp_valid_i = 1'b0;
    chk1 ("new_ivalid", bus.instr_valid_o, 1'b1);
    chk32("new_instr",  bus.instr_o,       32'h2000_AAAA);
    chk32("new_ipc",    bus.instr_pc_o,    32'h2000);
    bus.instr_ready_i = 1'b1;
    cyc();
    bus.instr_ready_i = 1'b0;
    chk1("popped_new", bus.instr_valid_o, 1'b0);

    // Redirect coinciding with a response: only one more response dropped
    bus.ic_req_ready_i = 1'b1;
    cyc();                                   // fire 0x2004
    cyc();                                   // fire 0x2008
    chk1 ("outst2_again", bus.ic_req_valid_o, 1'b0);
    chk32("addr_200c",    bus.ic_req_addr_o,  32'h200C);
    bus.redir_i        = 1'b1;
    bus.redir_pc_i     = 32'h3000;
    bus.ic_rsp_valid_i = 1'b1;
    bus.ic_rsp_data_i  = 32'hBAD0_0001;
    cyc();                                   // redirect + rsp 0x2004
    bus.redir_i       = 1'b0;
    bus.ic_rsp_data_i = 32'hBAD0_0002;
    #1;
    chk1 ("same_cyc_drop",  bus.instr_valid_o,  1'b0);
    chk1 ("same_cyc_req",   bus.ic_req_valid_o, 1'b1);
    chk32("same_cyc_addr",  bus.ic_req_addr_o,  32'h3000);
    cyc();                                   // fire 0x3000, rsp 0x2008 dropped
    chk1 ("last_drop", bus.instr_valid_o, 1'b0);
    chk32("addr_3004", bus.ic_req_addr_o, 32'h3004);
    bus.ic_req_ready_i = 1'b0;
    bus.ic_rsp_data_i  = 32'h3000_0042;
    cyc();                                   // rsp 0x3000 kept
    bus.ic_rsp_valid_i = 1'b0;
    chk1 ("drop_cnt_one", bus.instr_valid_o, 1'b1);
    chk32("instr_3000",   bus.instr_o,       32'h3000_0042);
    chk32("ipc_3000",     bus.instr_pc_o,    32'h3000);

    // Redirect beats pop and flushes; PC wraps past 0xFFFF_FFFC
    bus.redir_i       = 1'b1;
    bus.redir_pc_i    = 32'hFFFF_FFFF;
    bus.instr_ready_i = 1'b1;
    cyc();
    bus.redir_i       = 1'b0;
    bus.instr_ready_i = 1'b0;
    #1;
    chk1 ("redir_flush", bus.instr_valid_o,  1'b0);
    chk32("addr_top",    bus.ic_req_addr_o,  32'hFFFF_FFFC);
    chk1 ("valid_top",   bus.ic_req_valid_o, 1'b1);
    bus.ic_req_ready_i = 1'b1;
    cyc();                                   // fire 0xFFFF_FFFC
    bus.ic_req_ready_i = 1'b0;
    chk32("pc_wrap", bus.ic_req_addr_o, 32'h0);

    // Mid-operation reset: stale response afterwards is ignored
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus.ic_rsp_valid_i = 1'b1;
    bus.ic_rsp_data_i  = 32'h5555_5555;
    cyc();
    bus.ic_rsp_valid_i = 1'b0;
    chk1 ("stale_rsp", bus.instr_valid_o,  1'b0);
    chk32("rst2_addr", bus.ic_req_addr_o,  32'h100);
    chk1 ("rst2_req",  bus.ic_req_valid_o, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
